// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl: mixed-radix BCD countdown timer with button-driven preset editing
//   clk, rst_n                 clock, asynchronous active-low reset
//   btn_up/down/left/right     level buttons (debounced); rising edges edit the preset
//   btn_action                 level button; rising edge starts, stops or acknowledges
//   time_bcd                   current time, digit 0 in bits [3:0]
//   state                      00 RUN, 01 SETUP, 11 DONE
//   cursor                     index of the digit being edited
//   tick, done_pulse           one-cycle pulses on prescaler wrap and on expiry
module countdown_timer_ctrl #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1,
  parameter int N_DIGITS    = 4,
  parameter int MIXED_RADIX = 1,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        btn_up,
  input  logic                        btn_down,
  input  logic                        btn_left,
  input  logic                        btn_right,
  input  logic                        btn_action,
  output logic [4*N_DIGITS-1:0]       time_bcd,
  output logic [1:0]                  state,
  output logic [$clog2(N_DIGITS)-1:0] cursor,
  output logic                        tick,
  output logic                        done_pulse
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int CW  = $clog2(N_DIGITS);
  localparam int W   = 4 * N_DIGITS;

  typedef enum logic [1:0] {RUN = 2'b00, SETUP = 2'b01, DONE = 2'b11} stateT;

  stateT curState, nState;
  logic [W-1:0] preset, nPreset, nTime, decTime;
  logic [CW-1:0] nCursor;
  logic [PW-1:0] prescaler, nPresc;
  logic [4:0] btnPrev, btnNow, ev;
  logic nTick, nDone, borrow, wrap;
  logic actEv, upEv, downEv, leftEv, rightEv;
  logic [3:0] curDig, curMax;

  function automatic logic [3:0] digMax(input int i);
    return (MIXED_RADIX != 0 && i % 2 == 1) ? 4'd5 : 4'd9;
  endfunction

  assign btnNow  = {btn_action, btn_up, btn_down, btn_left, btn_right};
  assign ev      = btnNow & ~btnPrev;
  assign actEv   = ev[4];
  assign upEv    = ev[3];
  assign downEv  = ev[2];
  assign leftEv  = ev[1];
  assign rightEv = ev[0];
  assign wrap    = prescaler == PW'(DIV - 1);
  assign curDig  = time_bcd[{cursor, 2'b00} +: 4];
  assign curMax  = (MIXED_RADIX != 0 && cursor[0]) ? 4'd5 : 4'd9;
  assign state   = curState;

  // Ripple-borrow decrement: each digit at 0 wraps to its own maximum.
  always_comb begin
    decTime = time_bcd;
    borrow  = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      decTime[4*i +: 4] = borrow ? ((time_bcd[4*i +: 4] == 4'd0) ? digMax(i) : time_bcd[4*i +: 4] - 4'd1)
                                 : time_bcd[4*i +: 4];
      borrow = borrow && time_bcd[4*i +: 4] == 4'd0;
    end
  end

  // A present action event consumes the cycle even when it has no effect,
  // so lower-priority events in the same cycle are always dropped.
  always_comb begin
    nState  = curState;
    nTime   = time_bcd;
    nPreset = preset;
    nCursor = cursor;
    nTick   = 1'b0;
    nDone   = 1'b0;
    nPresc  = '0;
    case (curState)
      RUN:
        if (actEv) begin
          nState  = SETUP;
          nCursor = '0;
        end else if (wrap) begin
          nTick = 1'b1;
          if (decTime == '0) begin
            nDone = 1'b1;
            if (AUTO_RELOAD != 0) nTime = preset;
            else begin
              nTime  = '0;
              nState = DONE;
            end
          end else nTime = decTime;
        end else nPresc = prescaler + 1'b1;
      SETUP:
        if (actEv) begin
          if (time_bcd != '0) begin
            nPreset = time_bcd;
            nState  = RUN;
          end
        end else if (upEv) nTime[{cursor, 2'b00} +: 4] = (curDig == curMax) ? 4'd0 : curDig + 4'd1;
        else if (downEv) nTime[{cursor, 2'b00} +: 4] = (curDig == 4'd0) ? curMax : curDig - 4'd1;
        else if (leftEv) nCursor = (cursor == CW'(N_DIGITS - 1)) ? '0 : cursor + 1'b1;
        else if (rightEv) nCursor = (cursor == '0) ? CW'(N_DIGITS - 1) : cursor - 1'b1;
      DONE:
        if (actEv) begin
          nTime   = preset;
          nState  = SETUP;
          nCursor = '0;
        end
      default: nState = SETUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      curState   <= SETUP;
      time_bcd   <= '0;
      preset     <= '0;
      cursor     <= '0;
      tick       <= 1'b0;
      done_pulse <= 1'b0;
      prescaler  <= '0;
      btnPrev    <= '1;
    end else begin
      curState   <= nState;
      time_bcd   <= nTime;
      preset     <= nPreset;
      cursor     <= nCursor;
      tick       <= nTick;
      done_pulse <= nDone;
      prescaler  <= nPresc;
      btnPrev    <= btnNow;
    end
endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb_countdown_timer_ctrl: directed checks of the countdown timer, one-shot and auto-reload
module tb_countdown_timer_ctrl;
  localparam logic [4:0] A = 5'b10000, U = 5'b01000, D = 5'b00100, L = 5'b00010, R = 5'b00001;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] b1 = '0, b2 = '0;
  logic [15:0] t1, t2;
  logic [1:0] s1, s2, c1, c2;
  logic k1, k2, d1, d2;
  int errCount = 0, checkCount = 0;

  always #5 clk = ~clk;

  countdown_timer_ctrl #(.CLK_HZ(4), .TICK_HZ(1), .N_DIGITS(4), .MIXED_RADIX(1), .AUTO_RELOAD(0)) dut (
    .clk(clk), .rst_n(rst_n), .btn_up(b1[3]), .btn_down(b1[2]), .btn_left(b1[1]),
    .btn_right(b1[0]), .btn_action(b1[4]), .time_bcd(t1), .state(s1), .cursor(c1),
    .tick(k1), .done_pulse(d1));

  countdown_timer_ctrl #(.CLK_HZ(4), .TICK_HZ(1), .N_DIGITS(4), .MIXED_RADIX(1), .AUTO_RELOAD(1)) dutAr (
    .clk(clk), .rst_n(rst_n), .btn_up(b2[3]), .btn_down(b2[2]), .btn_left(b2[1]),
    .btn_right(b2[0]), .btn_action(b2[4]), .time_bcd(t2), .state(s2), .cursor(c2),
    .tick(k2), .done_pulse(d2));

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic press(input bit second, input logic [4:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (second) b2 = m; else b1 = m;
      @(negedge clk);
      if (second) b2 = '0; else b1 = '0;
    end
  endtask

  function automatic logic [15:0] mmss(input int sec);
    int m, s;
    m = sec / 60;
    s = sec % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  initial begin
    b1 = U;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_time", t1, 16'h0000);
    check("rst_state", {14'd0, s1}, 16'd1);
    check("rst_cursor", {14'd0, c1}, 16'd0);
    check("rst_tick", {15'd0, k1}, 16'd0);
    check("rst_done", {15'd0, d1}, 16'd0);
    @(negedge clk);
    check("held_up_no_event", t1, 16'h0000);
    b1 = '0;
    press(0, A, 1);
    check("action_zero_state", {14'd0, s1}, 16'd1);
    check("action_zero_time", t1, 16'h0000);
    press(0, U, 3);
    check("up3", t1, 16'h0003);
    press(0, L, 1);
    check("left_cursor", {14'd0, c1}, 16'd1);
    press(0, U, 6);
    check("base6_wrap", t1, 16'h0003);
    press(0, U, 3);
    check("up9_cursor1", t1, 16'h0033);
    press(0, D, 4);
    check("down4_wrap", t1, 16'h0053);
    press(0, D, 5);
    press(0, R, 1);
    check("right_cursor", {14'd0, c1}, 16'd0);
    press(0, R, 1);
    check("right_wrap", {14'd0, c1}, 16'd3);
    press(0, L, 1);
    check("left_wrap", {14'd0, c1}, 16'd0);
    press(0, D, 3);
    check("cleared", t1, 16'h0000);
    press(0, D, 1);
    check("base10_down_wrap", t1, 16'h0009);
    press(0, U, 1);
    press(0, L, 2);
    press(0, U, 1);
    check("preset_0100", t1, 16'h0100);
    press(0, A, 1);
    check("run_state", {14'd0, s1}, 16'd0);
    for (int k = 1; k <= 60; k++) begin
      repeat (3) begin
        @(negedge clk);
        check("no_tick", {15'd0, k1}, 16'd0);
      end
      @(negedge clk);
      check("tick", {15'd0, k1}, 16'd1);
      check("count", t1, mmss(60 - k));
      if (k < 60) check("no_done", {15'd0, d1}, 16'd0);
    end
    check("expired_state", {14'd0, s1}, 16'd3);
    check("expired_done", {15'd0, d1}, 16'd1);
    @(negedge clk);
    check("done_one_cycle", {15'd0, d1}, 16'd0);
    check("done_hold_time", t1, 16'h0000);
    press(0, U, 1);
    check("done_ignores_up", t1, 16'h0000);
    press(0, A, 1);
    check("ack_state", {14'd0, s1}, 16'd1);
    check("ack_time", t1, 16'h0100);
    check("ack_cursor", {14'd0, c1}, 16'd0);
    press(0, A | U, 1);
    check("act_up_state", {14'd0, s1}, 16'd0);
    check("act_up_time", t1, 16'h0100);
    repeat (4) @(negedge clk);
    check("rerun_tick", t1, 16'h0059);
    press(0, U, 1);
    check("run_ignores_up", t1, 16'h0059);
    b1 = U;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_time", t1, 16'h0000);
    check("async_rst_state", {14'd0, s1}, 16'd1);
    repeat (5) begin
      @(negedge clk);
      check("rst_no_tick", {15'd0, k1}, 16'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("held_through_rst", t1, 16'h0000);
    b1 = '0;
    press(0, U, 1);
    check("after_rst_up", t1, 16'h0001);

    press(1, U, 2);
    check("ar_preset", t2, 16'h0002);
    press(1, A, 1);
    check("ar_run", {14'd0, s2}, 16'd0);
    repeat (4) @(negedge clk);
    check("ar_tick1", t2, 16'h0001);
    check("ar_no_done1", {15'd0, d2}, 16'd0);
    repeat (4) @(negedge clk);
    check("ar_reload", t2, 16'h0002);
    check("ar_state", {14'd0, s2}, 16'd0);
    check("ar_done1", {15'd0, d2}, 16'd1);
    repeat (7) begin
      @(negedge clk);
      check("ar_done_gap", {15'd0, d2}, 16'd0);
    end
    @(negedge clk);
    check("ar_done2", {15'd0, d2}, 16'd1);
    check("ar_reload2", t2, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end
endmodule
